// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control sequencer for the fetch-stage PC register.
// Runs the instruction-memory req/ack handshake, arbitrates redirects
// (execute mispredict > interrupt > decode jump), drains any in-flight
// fetch, then holds a fixed flush bubble while the PC is reloaded.
module fetch_sequencer #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              HazardStall,
   output logic              IMemReq,
   input  logic              IMemAck,
   input  logic              ExRedirect,
   input  logic [ADDR_W-1:0] ExTarget,
   input  logic              IrqReq,
   input  logic [ADDR_W-1:0] IrqVector,
   output logic              IrqAck,
   input  logic              IdRedirect,
   input  logic [ADDR_W-1:0] IdTarget,
   output logic              FlushPipeandPC,
   output logic [ADDR_W-1:0] JmpAddr,
   output logic              PCStall,
   output logic              FetchValid
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      FLUSH
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t            state, state_nxt;
   logic              outstanding, outstanding_nxt;
   logic [ADDR_W-1:0] pend_target, pend_nxt;
   logic [ADDR_W-1:0] jmp_hold, jmp_hold_nxt;
   logic [3:0]        flush_cnt, flush_cnt_nxt;
   logic              flush_first, flush_first_nxt;

   logic              req_c;
   logic              ack_v;
   logic              stall_c;
   logic              valid_c;
   logic              flush_c;
   logic              irq_ack_c;
   logic [ADDR_W-1:0] jmp_c;
   logic              redirect;
   logic [ADDR_W-1:0] tgt;

   // State and bookkeeping registers; reset wins over everything.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= IDLE;
         outstanding <= 1'b0;
         pend_target <= '0;
         jmp_hold    <= '0;
         flush_cnt   <= '0;
         flush_first <= 1'b0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         pend_target <= pend_nxt;
         jmp_hold    <= jmp_hold_nxt;
         flush_cnt   <= flush_cnt_nxt;
         flush_first <= flush_first_nxt;
      end
   end

   // Next-state, redirect arbitration and output decode.
   always_comb begin
      state_nxt       = state;
      outstanding_nxt = outstanding;
      pend_nxt        = pend_target;
      jmp_hold_nxt    = jmp_hold;
      flush_cnt_nxt   = flush_cnt;
      flush_first_nxt = 1'b0;
      req_c           = 1'b0;
      ack_v           = 1'b0;
      stall_c         = 1'b1;
      valid_c         = 1'b0;
      flush_c         = 1'b0;
      irq_ack_c       = 1'b0;
      jmp_c           = jmp_hold;
      redirect        = 1'b0;
      tgt             = '0;

      case (state)
         IDLE: begin
            state_nxt = FETCH;
         end

         FETCH: begin
            redirect = ExRedirect | IrqReq | IdRedirect;
            if (redirect) begin
               // No new issue; only an already-outstanding fetch keeps req up.
               req_c = outstanding;
               ack_v = IMemAck & req_c;
               if (ExRedirect) begin
                  tgt = ExTarget;
               end else if (IrqReq) begin
                  tgt       = IrqVector;
                  irq_ack_c = 1'b1;
               end else begin
                  tgt = IdTarget;
               end
               pend_nxt = tgt;
               if (!outstanding || ack_v) begin
                  state_nxt       = FLUSH;
                  flush_cnt_nxt   = FLUSH_LOAD;
                  flush_first_nxt = 1'b1;
               end else begin
                  state_nxt = DRAIN;
               end
            end else begin
               req_c   = outstanding | ~HazardStall;
               ack_v   = IMemAck & req_c;
               valid_c = ack_v;
               stall_c = ~ack_v;
            end
         end

         DRAIN: begin
            req_c = 1'b1;
            ack_v = IMemAck;
            if (ExRedirect) begin
               pend_nxt = ExTarget;
            end
            if (ack_v) begin
               state_nxt       = FLUSH;
               flush_cnt_nxt   = FLUSH_LOAD;
               flush_first_nxt = 1'b1;
            end
         end

         FLUSH: begin
            if (flush_first) begin
               flush_c      = 1'b1;
               jmp_c        = pend_target;
               stall_c      = 1'b0;
               jmp_hold_nxt = pend_target;
            end
            if (ExRedirect) begin
               pend_nxt        = ExTarget;
               flush_cnt_nxt   = FLUSH_LOAD;
               flush_first_nxt = 1'b1;
            end else if (flush_cnt == 4'd0) begin
               state_nxt = FETCH;
            end else begin
               flush_cnt_nxt = flush_cnt - 4'd1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (ack_v) begin
         outstanding_nxt = 1'b0;
      end else if (req_c) begin
         outstanding_nxt = 1'b1;
      end

      // Outputs read as their reset values for the whole cycle Rst is high,
      // so a flush pulse cannot escape while the block is being reset.
      if (Rst) begin
         req_c     = 1'b0;
         stall_c   = 1'b1;
         valid_c   = 1'b0;
         flush_c   = 1'b0;
         irq_ack_c = 1'b0;
         jmp_c     = '0;
      end
   end

   assign IMemReq        = req_c;
   assign PCStall        = stall_c;
   assign FetchValid     = valid_c;
   assign FlushPipeandPC = flush_c;
   assign IrqAck         = irq_ack_c;
   assign JmpAddr        = jmp_c;

endmodule
